// File: rtl/tile_pkg.sv
// rtl/tile_pkg.sv - shared types, field positions and colour conversion for tile resolve
package tile_pkg;

  typedef logic [71:0] pixel72_t;
  typedef logic [31:0] rgba32_t;

  // Tile buffer pixel layout: {R16, G16, B16, depth24}
  localparam int COLOUR_MSB = 71;
  localparam int COLOUR_LSB = 24;
  localparam int DEPTH_MSB  = 23;
  localparam int DEPTH_LSB  = 0;
  localparam int R_MSB      = 71;
  localparam int G_MSB      = 55;
  localparam int B_MSB      = 39;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ_ROWS,
    ST_WAIT_RET,
    ST_DRAIN_ODD,
    ST_DONE
  } state_t;

  // Keep the top byte of each 16-bit channel; depth is discarded.
  function automatic rgba32_t to_rgb8(input pixel72_t p, input logic [7:0] alpha);
    return {alpha, p[R_MSB -: 8], p[G_MSB -: 8], p[B_MSB -: 8]};
  endfunction

endpackage

// File: rtl/resolve_fifo.sv
// rtl/resolve_fifo.sv - synchronous show-ahead FIFO carrying {last, user, data} beats
module resolve_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 130
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         push,
  input  logic [WIDTH-1:0]             din,
  input  logic                         pop,
  output logic [WIDTH-1:0]             dout,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Storage array, no reset needed: contents are only visible when count is non-zero
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy tracking; simultaneous push and pop leaves count unchanged
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/tile_resolve.sv
// rtl/tile_resolve.sv - sweeps the tile buffer in 2x2 quads and emits scanline-ordered RGB8 beats
module tile_resolve
  import tile_pkg::*;
#(
  parameter int         POS_ADDRW   = 8,
  parameter int         TILE_WIDTH  = 128,
  parameter int         TILE_HEIGHT = 128,
  parameter logic [7:0] OUT_ALPHA   = 8'hFF,
  parameter int         FIFO_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  i_start,
  input  logic                  i_tb_ready,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [POS_ADDRW-1:0]  o_read_x,
  output logic [POS_ADDRW-1:0]  o_read_y,
  output logic                  o_read_valid,
  input  logic [3:0][71:0]      i_read_data,
  input  logic                  i_read_valid,
  output logic [127:0]          m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tlast,
  output logic                  m_tuser
);

  localparam int BPR = TILE_WIDTH / 4;
  localparam int LBW = (BPR > 1) ? $clog2(BPR) : 1;
  localparam int CW  = $clog2(FIFO_DEPTH + 1);

  state_t                state;
  logic [POS_ADDRW-1:0]  qx;
  logic [POS_ADDRW-1:0]  ry;
  logic [LBW-1:0]        di;
  logic [LBW-1:0]        ret_beat;
  logic                  ret_odd;
  logic                  rd_pend;
  logic [CW-1:0]         pending;
  logic [CW-1:0]         fifo_count;
  logic [CW:0]           credit_sum;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  credit;
  logic                  issue;
  logic                  ret_ok;
  logic                  even_push;
  logic                  drain_push;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  even_last;
  logic                  even_user;
  logic                  drain_last;
  logic [129:0]          fifo_din;
  logic [129:0]          fifo_dout;
  logic [127:0]          hold;
  logic [127:0]          linebuf [BPR];
  logic [31:0]           px [4];
  logic                  unused_depth;

  assign unused_depth = ^{i_read_data[0][DEPTH_MSB:DEPTH_LSB], i_read_data[1][DEPTH_MSB:DEPTH_LSB],
                          i_read_data[2][DEPTH_MSB:DEPTH_LSB], i_read_data[3][DEPTH_MSB:DEPTH_LSB]};

  // A left-half quad reserves one FIFO slot for the even-row beat it will complete.
  assign credit_sum   = {1'b0, fifo_count} + {1'b0, pending};
  assign credit       = credit_sum < (CW+1)'(FIFO_DEPTH);
  assign issue        = (state == ST_READ_ROWS) && i_tb_ready && (qx[1] || credit);
  assign o_read_valid = issue;
  assign o_read_x     = qx;
  assign o_read_y     = {ry[POS_ADDRW-2:0], 1'b0};

  // Return data belongs to the quad issued last cycle; rd_pend drops stale returns after reset.
  assign ret_ok     = rd_pend && i_read_valid;
  assign even_push  = ret_ok && ret_odd;
  assign drain_push = (state == ST_DRAIN_ODD) && !fifo_full;
  assign fifo_push  = even_push || drain_push;
  assign fifo_pop   = m_tvalid && m_tready;
  assign even_last  = (ret_beat == LBW'(BPR - 1));
  assign even_user  = (ry == '0) && (ret_beat == '0);
  assign drain_last = (di == LBW'(BPR - 1));
  assign fifo_din   = even_push ? {even_last, even_user, px[1], px[0], hold[63:0]}
                                : {drain_last, 1'b0, linebuf[di]};

  // Convert all four returned pixels to RGB8
  always_comb begin
    for (int k = 0; k < 4; k++) px[k] = to_rgb8(i_read_data[k], OUT_ALPHA);
  end

  // Left quad is held until its right partner returns; odd-row halves wait in the line buffer
  always_ff @(posedge clk) begin
    if (ret_ok && !ret_odd) hold <= {px[3], px[2], px[1], px[0]};
    if (even_push)          linebuf[ret_beat] <= {px[3], px[2], hold[127:64]};
  end

  // Sequencer: quad issue, odd-row drain, completion handshake
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= ST_IDLE;
      qx       <= '0;
      ry       <= '0;
      di       <= '0;
      ret_beat <= '0;
      ret_odd  <= 1'b0;
      rd_pend  <= 1'b0;
      pending  <= '0;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
    end else begin
      o_done  <= 1'b0;
      rd_pend <= issue;
      if (issue) begin
        ret_odd  <= qx[1];
        ret_beat <= qx[LBW+1:2];
      end
      case ({issue && !qx[1], even_push})
        2'b10:   pending <= pending + 1'b1;
        2'b01:   pending <= pending - 1'b1;
        default: ;
      endcase
      case (state)
        ST_IDLE: begin
          if (i_start && i_tb_ready) begin
            state  <= ST_READ_ROWS;
            qx     <= '0;
            ry     <= '0;
            o_busy <= 1'b1;
          end
        end
        ST_READ_ROWS: begin
          if (issue) begin
            if (qx == POS_ADDRW'(TILE_WIDTH - 2)) state <= ST_WAIT_RET;
            else                                  qx    <= qx + POS_ADDRW'(2);
          end
        end
        ST_WAIT_RET: begin
          state <= ST_DRAIN_ODD;
          di    <= '0;
        end
        ST_DRAIN_ODD: begin
          if (drain_push) begin
            if (drain_last) begin
              if (ry == POS_ADDRW'(TILE_HEIGHT / 2 - 1)) begin
                state <= ST_DONE;
              end else begin
                ry    <= ry + 1'b1;
                qx    <= '0;
                state <= ST_READ_ROWS;
              end
            end else begin
              di <= di + 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (fifo_empty) begin
            state  <= ST_IDLE;
            o_busy <= 1'b0;
            o_done <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  resolve_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (130)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (fifo_push),
    .din   (fifo_din),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign m_tvalid = !fifo_empty;
  assign m_tdata  = fifo_empty ? '0 : fifo_dout[127:0];
  assign m_tuser  = !fifo_empty && fifo_dout[128];
  assign m_tlast  = !fifo_empty && fifo_dout[129];

endmodule

// File: tb/tb_tile_resolve.sv
// tb/tb_tile_resolve.sv - checks tile_resolve against a pixel-level model of the resolved tile
module tb_tile_resolve;

  localparam int W     = 128;
  localparam int H     = 128;
  localparam int BPR   = W / 4;
  localparam int TOTAL = W * H / 4;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rstn, i_start, i_tb_ready, i_read_valid, m_tready;
  logic            o_busy, o_done, o_read_valid, m_tvalid, m_tlast, m_tuser;
  logic [7:0]      o_read_x, o_read_y;
  logic [3:0][71:0] i_read_data;
  logic [127:0]    m_tdata;

  logic            s_start, s_tb_ready, s_rd_valid, s_tready;
  logic            s_busy, s_done, s_rvalid, s_tvalid, s_tlast, s_tuser;
  logic [7:0]      s_rx, s_ry;
  logic [3:0][71:0] s_rd_data;
  logic [127:0]    s_tdata;

  tile_resolve #(.POS_ADDRW(8), .TILE_WIDTH(W), .TILE_HEIGHT(H), .OUT_ALPHA(8'hFF), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn), .i_start(i_start), .i_tb_ready(i_tb_ready), .o_busy(o_busy), .o_done(o_done),
    .o_read_x(o_read_x), .o_read_y(o_read_y), .o_read_valid(o_read_valid), .i_read_data(i_read_data),
    .i_read_valid(i_read_valid), .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_tlast(m_tlast), .m_tuser(m_tuser));

  tile_resolve #(.POS_ADDRW(8), .TILE_WIDTH(8), .TILE_HEIGHT(2), .OUT_ALPHA(8'hFF), .FIFO_DEPTH(2)) dut_small (
    .clk(clk), .rstn(rstn), .i_start(s_start), .i_tb_ready(s_tb_ready), .o_busy(s_busy), .o_done(s_done),
    .o_read_x(s_rx), .o_read_y(s_ry), .o_read_valid(s_rvalid), .i_read_data(s_rd_data),
    .i_read_valid(s_rd_valid), .m_tdata(s_tdata), .m_tvalid(s_tvalid), .m_tready(s_tready),
    .m_tlast(s_tlast), .m_tuser(s_tuser));

  int n_cmp = 0;
  int n_bad = 0;
  int beats = 0;
  int done_cnt = 0;
  int drop_seen = 0;
  logic pattern_mode = 1'b0;
  logic rand_ready = 1'b0;
  logic drop_arm = 1'b0;
  logic drop_fired = 1'b0;
  logic [47:0] colour [H][W];

  task automatic chk(input string nm, input logic [129:0] act, input logic [129:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, want);
    end
  endtask

  function automatic logic [71:0] pat72(input int x, input int y);
    return {8'(x), 8'h00, 8'(y), 8'h00, 16'h1200, 24'h0};
  endfunction

  function automatic logic [31:0] conv(input logic [47:0] c);
    return {8'hFF, c[47:40], c[31:24], c[15:8]};
  endfunction

  // Beat idx of the tile in scanline order: row idx/BPR, pixels 4n..4n+3
  function automatic logic [129:0] model_beat(input int idx);
    int y, n;
    logic [127:0] d;
    y = idx / BPR;
    n = idx % BPR;
    for (int k = 0; k < 4; k++) d[32*k +: 32] = conv(colour[y][4*n+k]);
    return {n == BPR - 1, idx == 0, d};
  endfunction

  task automatic fill(input logic random_fill);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        colour[y][x] = random_fill ? 48'({$urandom, $urandom}) : pat72(x, y)[71:24];
  endtask

  // Tile buffer model for the large instance: fixed one-cycle read latency
  initial begin
    logic req;
    int rx, ry;
    i_read_valid = 1'b0;
    i_read_data = '0;
    forever begin
      @(negedge clk);
      req = o_read_valid;
      rx = int'(o_read_x);
      ry = int'(o_read_y);
      @(posedge clk); #1;
      i_read_valid = req;
      for (int k = 0; k < 4; k++)
        i_read_data[k] = req ? {colour[ry + k/2][rx + k%2], 24'($urandom)} : 72'({$urandom, $urandom, $urandom});
    end
  end

  // Tile buffer model for the small instance
  initial begin
    logic req;
    int rx, ry;
    s_rd_valid = 1'b0;
    s_rd_data = '0;
    forever begin
      @(negedge clk);
      req = s_rvalid;
      rx = int'(s_rx);
      ry = int'(s_ry);
      @(posedge clk); #1;
      s_rd_valid = req;
      for (int k = 0; k < 4; k++) s_rd_data[k] = pat72(rx + k%2, ry + k/2);
    end
  end

  // Downstream ready and tile-buffer-ready drivers
  initial begin
    int drop_left;
    drop_left = 0;
    m_tready = 1'b1;
    i_tb_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (drop_arm && !drop_fired && o_read_valid && o_read_y == 8'd10) begin
        drop_left = 10;
        drop_fired = 1'b1;
      end
      @(posedge clk); #1;
      m_tready = rand_ready ? ($urandom_range(0, 99) < 30) : 1'b1;
      if (drop_left > 0) begin
        i_tb_ready = 1'b0;
        drop_left--;
      end else begin
        i_tb_ready = 1'b1;
      end
    end
  end

  // Compare process for the large instance
  initial begin
    logic stalled;
    logic [129:0] held;
    stalled = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        beats = 0;
        stalled = 1'b0;
      end else begin
        if (i_start && !o_busy && i_tb_ready) beats = 0;
        if (o_read_valid) chk("read_x_even", o_read_x[0], 0);
        if (!i_tb_ready) begin
          drop_seen++;
          chk("read_valid_in_drop", o_read_valid, 0);
        end
        if (o_busy) chk("fifo_bound", dut.fifo_count <= DEPTH, 1);
        if (stalled) begin
          chk("stall_valid", m_tvalid, 1);
          chk("stall_stable", {m_tlast, m_tuser, m_tdata}, held);
        end
        if (m_tvalid && m_tready) begin
          if (beats >= TOTAL) chk("extra_beat", beats, TOTAL - 1);
          else chk("beat", {m_tlast, m_tuser, m_tdata}, model_beat(beats));
          if (pattern_mode) begin
            case (beats)
              0:         chk("pin_first", {m_tlast, m_tuser, m_tdata},
                             {1'b0, 1'b1, 128'hFF030012_FF020012_FF010012_FF000012});
              BPR - 1:   chk("pin_row0_last", {m_tlast, m_tuser, m_tdata},
                             {1'b1, 1'b0, 128'hFF7F0012_FF7E0012_FF7D0012_FF7C0012});
              BPR:       chk("pin_row1_first", {m_tlast, m_tuser, m_tdata},
                             {1'b0, 1'b0, 128'hFF030112_FF020112_FF010112_FF000112});
              TOTAL - 1: chk("pin_tile_last", {m_tlast, m_tuser, m_tdata},
                             {1'b1, 1'b0, 128'hFF7F7F12_FF7E7F12_FF7D7F12_FF7C7F12});
              default: ;
            endcase
          end
          beats++;
        end
        stalled = m_tvalid && !m_tready;
        held = {m_tlast, m_tuser, m_tdata};
        if (o_done) done_cnt++;
      end
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 i_start = 1'b1;
    @(posedge clk); #1 i_start = 1'b0;
  endtask

  task automatic wait_done(input int d0);
    int c;
    c = 0;
    while (done_cnt == d0 && c < 40000) begin
      @(negedge clk);
      c++;
    end
    chk("done_seen", done_cnt != d0, 1);
    repeat (5) @(negedge clk);
    chk("beat_total", beats, TOTAL);
    chk("done_count", done_cnt - d0, 1);
    chk("busy_after", o_busy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [129:0] sexp [4];
    int d0, got, c;
    rstn = 1'b0;
    i_start = 1'b0;
    s_start = 1'b0;
    s_tb_ready = 1'b1;
    s_tready = 1'b0;
    fill(1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_read_valid", o_read_valid, 0);
    chk("rst_tvalid", m_tvalid, 0);
    chk("rst_tlast", m_tlast, 0);
    chk("rst_tuser", m_tuser, 0);
    @(posedge clk); #1 rstn = 1'b1;

    // Small tile 8x2, FIFO depth 2, downstream held off for 20 cycles
    sexp[0] = {1'b0, 1'b1, 128'hFF030012_FF020012_FF010012_FF000012};
    sexp[1] = {1'b1, 1'b0, 128'hFF070012_FF060012_FF050012_FF040012};
    sexp[2] = {1'b0, 1'b0, 128'hFF030112_FF020112_FF010112_FF000112};
    sexp[3] = {1'b1, 1'b0, 128'hFF070112_FF060112_FF050112_FF040112};
    @(posedge clk); #1 s_start = 1'b1;
    @(posedge clk); #1 s_start = 1'b0;
    got = 0;
    for (c = 0; c < 300 && got < 4; c++) begin
      @(negedge clk);
      if (c == 19) begin
        chk("small_stall_valid", s_tvalid, 1);
        chk("small_stall_head", {s_tlast, s_tuser, s_tdata}, sexp[0]);
      end
      if (s_tvalid && s_tready) begin
        chk("small_beat", {s_tlast, s_tuser, s_tdata}, sexp[got]);
        got++;
      end
      @(posedge clk); #1;
      if (c == 19) s_tready = 1'b1;
    end
    chk("small_beat_count", got, 4);
    c = 0;
    while (!s_done && c < 50) begin
      @(negedge clk);
      c++;
    end
    chk("small_done", s_done, 1);
    chk("small_busy_drop", s_busy, 0);
    @(negedge clk);
    chk("small_no_extra", s_tvalid, 0);

    // Pattern tile, downstream always ready
    pattern_mode = 1'b1;
    d0 = done_cnt;
    pulse_start();
    wait_done(d0);
    pattern_mode = 1'b0;

    // Random colours, downstream ready about 30% of cycles
    fill(1'b1);
    rand_ready = 1'b1;
    d0 = done_cnt;
    pulse_start();
    wait_done(d0);
    rand_ready = 1'b0;

    // Tile buffer drop in row pair 5, plus a stray start while busy
    fill(1'b1);
    drop_arm = 1'b1;
    d0 = done_cnt;
    pulse_start();
    repeat (98) @(posedge clk);
    pulse_start();
    wait_done(d0);
    chk("drop_cycles", drop_seen, 10);
    drop_arm = 1'b0;

    // One-cycle reset mid-tile, then a full tile
    fill(1'b1);
    pulse_start();
    repeat (300) @(posedge clk);
    #1 rstn = 1'b0;
    @(posedge clk); #1 rstn = 1'b1;
    @(negedge clk);
    chk("midrst_busy", o_busy, 0);
    chk("midrst_done", o_done, 0);
    chk("midrst_read_valid", o_read_valid, 0);
    chk("midrst_tvalid", m_tvalid, 0);
    chk("midrst_tlast", m_tlast, 0);
    chk("midrst_tuser", m_tuser, 0);
    chk("midrst_tdata", m_tdata, 0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("post_rst_quiet", m_tvalid, 0);
    end
    d0 = done_cnt;
    pulse_start();
    wait_done(d0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
